// File: rtl/dot_product_scheduler_if.sv
// Bundle of requester, vector-memory and datapath signals around the shared dot-product scheduler.
// The master view belongs to the scheduler; the slave view belongs to the surrounding environment.
interface dot_product_scheduler_if #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int N_REQ         = 2
);
    logic [N_REQ-1:0]                     req_valid;
    logic [32*N_REQ-1:0]                  req_total;
    logic [ADDR_WIDTH*N_REQ-1:0]          req_base_a;
    logic [ADDR_WIDTH*N_REQ-1:0]          req_base_b;
    logic [N_REQ-1:0]                     grant;
    logic [N_REQ-1:0]                     req_done;
    logic [ELEMENT_WIDTH-1:0]             result;
    logic                                 mem_rd_en;
    logic [ADDR_WIDTH-1:0]                mem_addr_a;
    logic [ADDR_WIDTH-1:0]                mem_addr_b;
    logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_data_a;
    logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_data_b;
    logic                                 dp_clear;
    logic                                 dp_valid;
    logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_row_a;
    logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_row_b;
    logic [31:0]                          dp_total;
    logic                                 dp_ready;
    logic                                 dp_finish;
    logic [ELEMENT_WIDTH-1:0]             dp_result;

    modport master (
        input  req_valid, req_total, req_base_a, req_base_b,
        input  mem_data_a, mem_data_b, dp_ready, dp_finish, dp_result,
        output grant, req_done, result, mem_rd_en, mem_addr_a, mem_addr_b,
        output dp_clear, dp_valid, dp_row_a, dp_row_b, dp_total
    );

    modport slave (
        output req_valid, req_total, req_base_a, req_base_b,
        output mem_data_a, mem_data_b, dp_ready, dp_finish, dp_result,
        input  grant, req_done, result, mem_rd_en, mem_addr_a, mem_addr_b,
        input  dp_clear, dp_valid, dp_row_a, dp_row_b, dp_total
    );
endinterface

// File: rtl/dot_product_scheduler.sv
// Round-robin scheduler that streams chunk pairs from a two-port vector memory
// into one shared dot-product datapath on behalf of N_REQ requesters.
module dot_product_scheduler #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int N_REQ         = 2
) (
    input logic clk,
    input logic reset,
    dot_product_scheduler_if.master bus
);
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LANE_W = $clog2(NO_OF_UNITS + 1);
    localparam int ROW_W  = ELEMENT_WIDTH * NO_OF_UNITS;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, WAIT_FIN, DONE} state_t;

    state_t                   state_q;
    logic [N_REQ-1:0]         grant_q, reqDone_q;
    logic [ID_W-1:0]          id_q, lastGrant_q;
    logic [ELEMENT_WIDTH-1:0] result_q;
    logic [31:0]              total_q;
    logic [ADDR_WIDTH-1:0]    baseA_q, baseB_q, addrA_q, addrB_q;
    logic [32:0]              beats_q, beatCnt_q;
    logic [LANE_W-1:0]        tail_q;
    logic                     memRdEn_q, lastRd_q, dpClear_q, dpValid_q, lastBeat_q;

    logic                     pickValid_d;
    logic [ID_W-1:0]          pickId_d;
    logic [31:0]              totalSel_d;
    logic [ADDR_WIDTH-1:0]    baseASel_d, baseBSel_d;
    logic [32:0]              beatsSel_d;
    logic [LANE_W-1:0]        tailSel_d;
    logic                     issue_d;
    logic [ROW_W-1:0]         rowA_d, rowB_d;

    // First pending requester searching upward from the one after the last owner.
    always_comb begin
        int idx;
        idx         = 0;
        pickValid_d = 1'b0;
        pickId_d    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(lastGrant_q) + i) % N_REQ;
            if (!pickValid_d && bus.req_valid[idx]) begin
                pickValid_d = 1'b1;
                pickId_d    = ID_W'(idx);
            end
        end
    end

    // Tail is the number of live lanes in the final beat (1..NO_OF_UNITS).
    always_comb begin
        totalSel_d = bus.req_total[int'(pickId_d)*32 +: 32];
        baseASel_d = bus.req_base_a[int'(pickId_d)*ADDR_WIDTH +: ADDR_WIDTH];
        baseBSel_d = bus.req_base_b[int'(pickId_d)*ADDR_WIDTH +: ADDR_WIDTH];
        beatsSel_d = ({1'b0, totalSel_d} + 33'(NO_OF_UNITS - 1)) / 33'(NO_OF_UNITS);
        tailSel_d  = ((totalSel_d % 32'(NO_OF_UNITS)) == 32'd0) ? LANE_W'(NO_OF_UNITS)
                                                              : LANE_W'(totalSel_d % 32'(NO_OF_UNITS));
        issue_d    = ((state_q == CLEAR) || (state_q == STREAM)) && bus.dp_ready && (beatCnt_q < beats_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            reqDone_q   <= '0;
            id_q        <= '0;
            lastGrant_q <= ID_W'(N_REQ - 1);
            result_q    <= '0;
            total_q     <= '0;
            baseA_q     <= '0;
            baseB_q     <= '0;
            addrA_q     <= '0;
            addrB_q     <= '0;
            beats_q     <= '0;
            beatCnt_q   <= '0;
            tail_q      <= '0;
            memRdEn_q   <= 1'b0;
            lastRd_q    <= 1'b0;
            dpClear_q   <= 1'b0;
            dpValid_q   <= 1'b0;
            lastBeat_q  <= 1'b0;
        end else begin
            memRdEn_q  <= issue_d;
            dpClear_q  <= 1'b0;
            dpValid_q  <= memRdEn_q;
            lastBeat_q <= memRdEn_q && lastRd_q;
            if (issue_d) begin
                addrA_q   <= baseA_q + beatCnt_q[ADDR_WIDTH-1:0];
                addrB_q   <= baseB_q + beatCnt_q[ADDR_WIDTH-1:0];
                lastRd_q  <= (beatCnt_q == beats_q - 33'd1);
                beatCnt_q <= beatCnt_q + 33'd1;
            end
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        id_q      <= pickId_d;
                        grant_q   <= N_REQ'(1) << pickId_d;
                        total_q   <= totalSel_d;
                        baseA_q   <= baseASel_d;
                        baseB_q   <= baseBSel_d;
                        beats_q   <= beatsSel_d;
                        tail_q    <= tailSel_d;
                        beatCnt_q <= '0;
                        if (totalSel_d == 32'd0) begin
                            result_q  <= '0;
                            reqDone_q <= N_REQ'(1) << pickId_d;
                            state_q   <= DONE;
                        end else begin
                            dpClear_q <= 1'b1;
                            state_q   <= CLEAR;
                        end
                    end
                end
                CLEAR:  state_q <= STREAM;
                STREAM: if (memRdEn_q && lastRd_q) state_q <= DRAIN;
                DRAIN:  state_q <= WAIT_FIN;
                WAIT_FIN: begin
                    if (bus.dp_finish) begin
                        result_q  <= bus.dp_result;
                        reqDone_q <= grant_q;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    reqDone_q   <= '0;
                    grant_q     <= '0;
                    lastGrant_q <= id_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory data lands one cycle after the read, so rows pass through combinationally.
    always_comb begin
        rowA_d = '0;
        rowB_d = '0;
        for (int k = 0; k < NO_OF_UNITS; k++) begin
            if (dpValid_q && (!lastBeat_q || (LANE_W'(k) < tail_q))) begin
                rowA_d[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = bus.mem_data_a[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                rowB_d[k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = bus.mem_data_b[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.req_done   = reqDone_q;
    assign bus.result     = result_q;
    assign bus.mem_rd_en  = memRdEn_q;
    assign bus.mem_addr_a = addrA_q;
    assign bus.mem_addr_b = addrB_q;
    assign bus.dp_clear   = dpClear_q;
    assign bus.dp_valid   = dpValid_q;
    assign bus.dp_row_a   = rowA_d;
    assign bus.dp_row_b   = rowB_d;
    assign bus.dp_total   = total_q;
endmodule
